// File: rtl/fetch_dual_pkg.sv
// Shared definitions for the dual-issue fetch stage: default widths, bubble word
// and the 2-bit branch counter encoding with its saturating update.
package fetch_dual_pkg;

  localparam int          PC_W_DEF      = 13;
  localparam int          BTB_IDX_W_DEF = 4;
  localparam logic [31:0] NOP           = 32'd0;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic logic ctr_taken(input ctr_e c);
    return (c == CTR_WT) || (c == CTR_ST);
  endfunction

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_dual_btb.sv
// Direct-mapped BTB: two combinational lookup ports, one update port written at the edge.
// Lookups always see pre-edge contents; updates are never blocked, only RST suppresses them.
module fetch_dual_btb
  import fetch_dual_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int BTB_IDX_W = BTB_IDX_W_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [PC_W-3:0] i_rd_wa1,
  input  logic [PC_W-3:0] i_rd_wa2,
  output logic            o_hit1,
  output logic            o_hit2,
  output logic [PC_W-1:0] o_tgt1,
  output logic [PC_W-1:0] o_tgt2,
  input  logic            i_upd_en,
  input  logic [PC_W-3:0] i_upd_wa,
  input  logic [PC_W-1:0] i_upd_tgt,
  input  logic            i_upd_taken
);

  localparam int N     = 1 << BTB_IDX_W;
  localparam int TAG_W = PC_W - 2 - BTB_IDX_W;

  logic             r_vld [N];
  logic [TAG_W-1:0] r_tag [N];
  logic [PC_W-1:0]  r_tgt [N];
  ctr_e             r_ctr [N];

  logic [BTB_IDX_W-1:0] w_idx1, w_idx2, w_uidx;
  logic [TAG_W-1:0]     w_tag1, w_tag2, w_utag;
  logic                 w_uhit;

  assign w_idx1 = i_rd_wa1[BTB_IDX_W-1:0];
  assign w_idx2 = i_rd_wa2[BTB_IDX_W-1:0];
  assign w_uidx = i_upd_wa[BTB_IDX_W-1:0];
  assign w_tag1 = i_rd_wa1[PC_W-3:BTB_IDX_W];
  assign w_tag2 = i_rd_wa2[PC_W-3:BTB_IDX_W];
  assign w_utag = i_upd_wa[PC_W-3:BTB_IDX_W];

  assign o_hit1 = r_vld[w_idx1] && (r_tag[w_idx1] == w_tag1) && ctr_taken(r_ctr[w_idx1]);
  assign o_hit2 = r_vld[w_idx2] && (r_tag[w_idx2] == w_tag2) && ctr_taken(r_ctr[w_idx2]);
  assign o_tgt1 = r_tgt[w_idx1];
  assign o_tgt2 = r_tgt[w_idx2];

  assign w_uhit = r_vld[w_uidx] && (r_tag[w_uidx] == w_utag);

  // A not-taken miss leaves the entry untouched; a taken miss allocates weakly-taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        r_vld[i] <= 1'b0;
        r_ctr[i] <= CTR_SNT;
      end
    end else if (i_upd_en) begin
      if (w_uhit) begin
        r_ctr[w_uidx] <= ctr_next(r_ctr[w_uidx], i_upd_taken);
      end else if (i_upd_taken) begin
        r_vld[w_uidx] <= 1'b1;
        r_ctr[w_uidx] <= CTR_WT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && i_upd_en && i_upd_taken) begin
      r_tag[w_uidx] <= w_utag;
      r_tgt[w_uidx] <= i_upd_tgt;
    end
  end

endmodule

// File: rtl/fetch_dual.sv
// Dual-issue fetch: PC register, BTB prediction and next-PC selection; outputs are 0-cycle.
// No handshake: stall freezes PC and dep_q, E redirect overrides stall, D redirect does not.
module fetch_dual
  import fetch_dual_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BTB_IDX_W = BTB_IDX_W_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [PC_W-1:0] imem_addr1,
  output logic [PC_W-1:0] imem_addr2,
  input  logic [31:0]     imem_rdata1,
  input  logic [31:0]     imem_rdata2,
  output logic [PC_W-1:0] pc1_out,
  output logic [PC_W-1:0] pc2_out,
  output logic [31:0]     inst1_out,
  output logic [31:0]     inst2_out,
  output logic            hit_predict1,
  output logic            hit_predict2,
  input  logic            is_depend,
  input  logic            stall,
  input  logic            fail_predictD,
  input  logic [PC_W-1:0] target_D,
  input  logic            fail_predictE,
  input  logic [PC_W-1:0] target_E,
  input  logic            bu_en,
  input  logic [PC_W-1:0] bu_pc,
  input  logic [PC_W-1:0] bu_target,
  input  logic            bu_taken
);

  localparam logic [PC_W-1:0] PC_STEP1 = PC_W'(4);
  localparam logic [PC_W-1:0] PC_STEP2 = PC_W'(8);

  logic [PC_W-1:0] r_pc;
  logic            r_dep;

  logic [PC_W-1:0] w_pc2, w_pc_nxt, w_tgt1, w_tgt2;
  logic            w_hit1, w_hit2, w_redirect;
  logic            w_unused_bu_lsb;

  assign w_pc2           = r_pc + PC_STEP1;
  assign w_redirect      = fail_predictE | (fail_predictD & ~stall);
  assign w_unused_bu_lsb = ^bu_pc[1:0];

  fetch_dual_btb #(
    .PC_W      (PC_W),
    .BTB_IDX_W (BTB_IDX_W)
  ) u_btb (
    .CLK         (CLK),
    .RST         (RST),
    .i_rd_wa1    (r_pc[PC_W-1:2]),
    .i_rd_wa2    (w_pc2[PC_W-1:2]),
    .o_hit1      (w_hit1),
    .o_hit2      (w_hit2),
    .o_tgt1      (w_tgt1),
    .o_tgt2      (w_tgt2),
    .i_upd_en    (bu_en),
    .i_upd_wa    (bu_pc[PC_W-1:2]),
    .i_upd_tgt   (bu_target),
    .i_upd_taken (bu_taken)
  );

  assign imem_addr1   = r_pc;
  assign imem_addr2   = w_pc2;
  assign pc1_out      = r_pc;
  assign pc2_out      = w_pc2;
  assign inst1_out    = imem_rdata1;
  assign inst2_out    = w_hit1 ? NOP : imem_rdata2;
  assign hit_predict1 = w_hit1;
  assign hit_predict2 = w_hit2 & ~w_hit1;

  // When the check stage held slot 2 back, refetch it and disregard its prediction.
  always_comb begin
    w_pc_nxt = r_pc + PC_STEP2;
    if (fail_predictE)                w_pc_nxt = target_E;
    else if (fail_predictD && !stall) w_pc_nxt = target_D;
    else if (stall)                   w_pc_nxt = r_pc;
    else if (w_hit1)                  w_pc_nxt = w_tgt1;
    else if (r_dep)                   w_pc_nxt = w_pc2;
    else if (w_hit2)                  w_pc_nxt = w_tgt2;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc  <= RESET_PC;
      r_dep <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_redirect)  r_dep <= 1'b0;
      else if (!stall) r_dep <= is_depend;
    end
  end

endmodule
